// File: rtl/mm2s_channel.sv
// rtl/mm2s_channel.sv - AXI4 MM read to AXI-Stream DMA channel with 4KB-safe INCR bursts.
// Optional MM2S_ERR_STATUS_EN adds mm2s_err_o holding the first non-OKAY rresp of a transfer.
module mm2s_channel #(
  parameter int C_AXI_MM_ID_WIDTH   = 4,
  parameter int C_AXI_MM_ADDR_WIDTH = 32,
  parameter int C_AXI_MM_DATA_WIDTH = 64,
  parameter int C_AXI_ID            = 0,
  parameter int C_MAX_BURST_LEN     = 16
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
`ifdef MM2S_ERR_STATUS_EN
  output logic [1:0]                           mm2s_err_o,
`endif
  input  logic                                 mm2s_start_i,
  input  logic [C_AXI_MM_ADDR_WIDTH-1:0]       mm2s_src_addr_i,
  input  logic [31:0]                          mm2s_length_i,
  input  logic                                 mm2s_reset_i,
  output logic                                 mm2s_busy_o,
  output logic                                 mm2s_irq_o,
  output logic [C_AXI_MM_ID_WIDTH-1:0]         m_axi_arid_o,
  output logic [C_AXI_MM_ADDR_WIDTH-1:0]       m_axi_araddr_o,
  output logic [7:0]                           m_axi_arlen_o,
  output logic [2:0]                           m_axi_arsize_o,
  output logic [1:0]                           m_axi_arburst_o,
  output logic [3:0]                           m_axi_arcache_o,
  output logic [2:0]                           m_axi_arprot_o,
  output logic                                 m_axi_arvalid_o,
  input  logic                                 m_axi_arready_i,
  input  logic [C_AXI_MM_ID_WIDTH-1:0]         m_axi_rid_i,
  input  logic [C_AXI_MM_DATA_WIDTH-1:0]       m_axi_rdata_i,
  input  logic [1:0]                           m_axi_rresp_i,
  input  logic                                 m_axi_rlast_i,
  input  logic                                 m_axi_rvalid_i,
  output logic                                 m_axi_rready_o,
  output logic [C_AXI_MM_DATA_WIDTH-1:0]       m_axis_tdata_o,
  output logic [C_AXI_MM_DATA_WIDTH/8-1:0]     m_axis_tkeep_o,
  output logic                                 m_axis_tlast_o,
  output logic                                 m_axis_tvalid_o,
  input  logic                                 m_axis_tready_i
);
  localparam int AW    = C_AXI_MM_ADDR_WIDTH;
  localparam int DW    = C_AXI_MM_DATA_WIDTH;
  localparam int B     = DW / 8;
  localparam int LOG2B = $clog2(B);

  typedef enum logic [2:0] {S_IDLE, S_AR, S_DATA, S_DONE, S_FLUSH} state_t;

  state_t          state_q;
  logic [AW-1:0]   addr_q;
  logic [32:0]     rem_q;
  logic [32:0]     emit_q;
  logic [B-1:0]    keep_last_q;
  logic            err_q;
  logic            flush_pend_q;
  logic            busy_q;
  logic            irq_q;
  logic            arvalid_q;
  logic [DW-1:0]   tdata_q;
  logic [B-1:0]    tkeep_q;
  logic            tlast_q;
  logic            tvalid_q;
`ifdef MM2S_ERR_STATUS_EN
  logic [1:0]      err_st_q;
`endif

  logic [12:0]     to_4k_bytes;
  logic [12:0]     to_4k_beats;
  logic [8:0]      burst_beats;
  logic [AW-1:0]   addr_next_d;
  logic [32:0]     rem_next_d;
  logic [32:0]     beats_total_d;
  logic [LOG2B-1:0] len_mod;
  logic [B-1:0]    keep_last_d;
  logic            ar_hs;
  logic            r_hs;
  logic            beat_bad;
  logic            unused;

  assign unused = ^m_axi_rid_i;

  // Burst size is the smallest of what is left, the burst cap and the room to the next 4KB page.
  assign to_4k_bytes = 13'h1000 - {1'b0, addr_q[11:0]};
  assign to_4k_beats = to_4k_bytes >> LOG2B;
  always_comb begin
    burst_beats = 9'(C_MAX_BURST_LEN);
    if (rem_q < 33'(C_MAX_BURST_LEN)) burst_beats = rem_q[8:0];
    if (to_4k_beats < {4'b0000, burst_beats}) burst_beats = to_4k_beats[8:0];
  end

  assign addr_next_d   = addr_q + (AW'(burst_beats) << LOG2B);
  assign rem_next_d    = (rem_q > 33'(burst_beats)) ? rem_q - 33'(burst_beats) : 33'd0;
  assign beats_total_d = (33'(mm2s_length_i) + 33'(B - 1)) >> LOG2B;
  assign len_mod       = mm2s_length_i[LOG2B-1:0];
  assign keep_last_d   = (len_mod == '0) ? {B{1'b1}} : ~({B{1'b1}} << len_mod);

  assign m_axi_rready_o = (state_q == S_FLUSH) ||
                          ((state_q == S_DATA) && (err_q || !tvalid_q || m_axis_tready_i));
  assign ar_hs    = arvalid_q && m_axi_arready_i;
  assign r_hs     = m_axi_rvalid_i && m_axi_rready_o;
  assign beat_bad = err_q || (m_axi_rresp_i != 2'b00);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      rem_q        <= '0;
      emit_q       <= '0;
      keep_last_q  <= '0;
      err_q        <= 1'b0;
      flush_pend_q <= 1'b0;
      busy_q       <= 1'b0;
      irq_q        <= 1'b0;
      arvalid_q    <= 1'b0;
      tdata_q      <= '0;
      tkeep_q      <= '0;
      tlast_q      <= 1'b0;
      tvalid_q     <= 1'b0;
`ifdef MM2S_ERR_STATUS_EN
      err_st_q     <= 2'b00;
`endif
    end else begin
      irq_q <= 1'b0;
      if (tvalid_q && m_axis_tready_i) begin
        tvalid_q <= 1'b0;
        tlast_q  <= 1'b0;
      end
      case (state_q)
        S_IDLE: begin
          if (mm2s_start_i && !mm2s_reset_i) begin
            busy_q <= 1'b1;
            err_q  <= 1'b0;
`ifdef MM2S_ERR_STATUS_EN
            err_st_q <= 2'b00;
`endif
            if (mm2s_length_i != 32'd0) begin
              addr_q      <= mm2s_src_addr_i & ~AW'(B - 1);
              rem_q       <= beats_total_d;
              emit_q      <= beats_total_d;
              keep_last_q <= keep_last_d;
              arvalid_q   <= 1'b1;
              state_q     <= S_AR;
            end else begin
              state_q <= S_DONE;
            end
          end
        end
        S_AR: begin
          if (ar_hs) begin
            arvalid_q    <= 1'b0;
            addr_q       <= addr_next_d;
            rem_q        <= rem_next_d;
            flush_pend_q <= 1'b0;
            state_q      <= (mm2s_reset_i || flush_pend_q) ? S_FLUSH : S_DATA;
          end else if (mm2s_reset_i) begin
            flush_pend_q <= 1'b1;
          end
        end
        S_DATA: begin
          if (mm2s_reset_i) begin
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
            if (r_hs && m_axi_rlast_i) begin
              busy_q  <= 1'b0;
              state_q <= S_IDLE;
            end else begin
              state_q <= S_FLUSH;
            end
          end else if (r_hs) begin
            if (beat_bad) begin
              err_q <= 1'b1;
`ifdef MM2S_ERR_STATUS_EN
              if (!err_q) err_st_q <= m_axi_rresp_i;
`endif
            end else if (emit_q != 33'd0) begin
              tdata_q  <= m_axi_rdata_i;
              tkeep_q  <= (emit_q == 33'd1) ? keep_last_q : {B{1'b1}};
              tlast_q  <= (emit_q == 33'd1);
              tvalid_q <= 1'b1;
              emit_q   <= emit_q - 33'd1;
            end
            if (m_axi_rlast_i) begin
              if (beat_bad || rem_q == 33'd0) begin
                state_q <= S_DONE;
              end else begin
                arvalid_q <= 1'b1;
                state_q   <= S_AR;
              end
            end
          end
        end
        S_DONE: begin
          if (mm2s_reset_i) begin
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
            busy_q   <= 1'b0;
            state_q  <= S_IDLE;
          end else if (!tvalid_q || m_axis_tready_i) begin
            irq_q   <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        S_FLUSH: begin
          tvalid_q <= 1'b0;
          tlast_q  <= 1'b0;
          if (r_hs && m_axi_rlast_i) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign mm2s_busy_o     = busy_q;
  assign mm2s_irq_o      = irq_q;
  assign m_axi_arid_o    = C_AXI_MM_ID_WIDTH'(C_AXI_ID);
  assign m_axi_araddr_o  = addr_q;
  assign m_axi_arlen_o   = arvalid_q ? 8'(burst_beats - 9'd1) : 8'd0;
  assign m_axi_arsize_o  = 3'(LOG2B);
  assign m_axi_arburst_o = 2'b01;
  assign m_axi_arcache_o = 4'b0011;
  assign m_axi_arprot_o  = 3'b000;
  assign m_axi_arvalid_o = arvalid_q;
  assign m_axis_tdata_o  = tdata_q;
  assign m_axis_tkeep_o  = tkeep_q;
  assign m_axis_tlast_o  = tlast_q;
  assign m_axis_tvalid_o = tvalid_q;
`ifdef MM2S_ERR_STATUS_EN
  assign mm2s_err_o      = err_st_q;
`endif
endmodule
